// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int UART_OVERSAMPLE_DEF = 16;

    function automatic int div_calc(
        input int clk_hz,
        input int baud,
        input int os
    );
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through register-array FIFO with occupancy count.
module rx_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       valid,
    output logic [WIDTH-1:0]           data,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [LW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    assign valid   = (cnt != '0);
    assign full    = (cnt == LW'(DEPTH));
    assign do_pop  = pop && valid;
    // A pop frees the slot, so a push to a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign data    = valid ? mem[rd_ptr] : '0;
    assign level   = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                cnt <= cnt + LW'(1);
            else if (!do_push && do_pop)
                cnt <= cnt - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN to build the parity bit check.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int DEPTH      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx,
    output logic [DATA_BITS-1:0]       m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       frame_err,
    output logic                       overrun,
    output logic                       parity_err
);

    import uart_pkg::*;

    localparam int DIV = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LO  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_HI  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_div_err
        $error("uart_rx_fifo: CLK_HZ/(BAUD*OVERSAMPLE) < 1");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_os_err
        $error("uart_rx_fifo: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_err
        $error("uart_rx_fifo: DATA_BITS must be 5..9");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_dp_err
        $error("uart_rx_fifo: DEPTH must be a power of 2, >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_po_err
        $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
    end

    rx_state_t            state;
    logic                 rx_s1;
    logic                 rx_sync;
    logic                 rx_d;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic                 push_q;
    logic                 fifo_full;
    logic                 tick;
    logic                 start_edge;
    logic                 mid;
    logic                 bit_end;
    logic                 vote;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
    logic                 perr_q;
`endif

    assign tick       = (div_cnt == DW'(DIV - 1));
    assign start_edge = (state == IDLE) && rx_d && !rx_sync;
    assign mid        = tick && (tick_cnt == T_HI);
    assign bit_end    = tick && (tick_cnt == T_END);
    assign vote       = (smp[1] & smp[0]) | (smp[1] & rx_sync)
                      | (smp[0] & rx_sync);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_sync    <= 1'b1;
            rx_d       <= 1'b1;
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            smp        <= '0;
            shreg      <= '0;
            push_q     <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_s1     <= rx;
            rx_sync   <= rx_s1;
            rx_d      <= rx_sync;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= push_q && fifo_full && !(m_valid && m_ready);
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            if (tick && (tick_cnt == T_LO || tick_cnt == T_MID))
                smp <= {smp[0], rx_sync};
            if (tick && state != IDLE && state != BREAK)
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (mid && vote) begin
                        state <= IDLE;
                    end else if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (mid)
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid)
                        par_bad <= vote ^ (^shreg) ^ 1'(PARITY_ODD);
                    if (bit_end)
                        state <= STOP;
                end
`endif
                STOP: begin
`ifdef UART_RX_PARITY_EN
                    if (mid && par_bad) begin
                        perr_q    <= 1'b1;
                        frame_err <= !vote;
                        state     <= vote ? IDLE : BREAK;
                        tick_cnt  <= '0;
                    end else
`endif
                    if (mid) begin
                        tick_cnt <= '0;
                        if (vote) begin
                            push_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Leave only after a full bit time of continuous idle.
                    if (tick) begin
                        if (!rx_sync)
                            tick_cnt <= '0;
                        else if (tick_cnt == T_END)
                            state <= IDLE;
                        else
                            tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    rx_byte_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (shreg),
        .pop       (m_ready),
        .full      (fifo_full),
        .valid     (m_valid),
        .data      (m_data),
        .level     (level)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver replacing the fixed 9600-baud receiver in front of the keyboard/Bluetooth command parser.
- Oversamples the rx line and rejects glitches with majority voting.
- Checks framing, and parity when enabled.
- Buffers received bytes in a first-word-fall-through FIFO with a valid/ready output, so the ASCII line parser can stall without losing bytes.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: oversample ticks per bit. Even, ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9. Sent LSB first.
- DEPTH, 16: FIFO entries. Power of 2, ≥ 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only with UART_RX_PARITY_EN.

Ports:
- clk  in  1  system clock. One clock domain.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- m_data  out  DATA_BITS  byte at the FIFO head.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts m_data this cycle.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: byte dropped because the FIFO was full.
- parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - Synchroniser flops to 1; state to IDLE; counters to 0.
  - FIFO emptied: level=0, m_valid=0, m_data=0.
  - All error pulses 0.
  - Reset mid-frame abandons the partial byte; no pulse is generated.
- Input synchroniser: 2-FF on rx. All decisions use the synchronised value.
- Tick generator: DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer truncation. DIV < 1 is an elaboration error.
  - One-cycle tick every DIV clocks, free-running.
  - Tick phase and the tick counter within a bit are reset on start-edge detection.
- Sampling: each bit value is the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP, BREAK.
  - IDLE -> START on a synchronised falling edge.
  - START: if the mid-bit vote is 1, treat it as a false start and return to IDLE with no pulse. Otherwise go to DATA at the bit end.
  - DATA: shift in DATA_BITS votes, LSB first; then go to PARITY or STOP.
  - PARITY: vote the parity bit, compare against the data parity, then go to STOP.
  - STOP, vote = 1 and no parity error: push the byte into the FIFO at the mid-stop decision and return to IDLE. The receiver can then resync to a following start edge within half a bit.
  - STOP, vote = 0: pulse frame_err, drop the byte, go to BREAK.
  - STOP with a parity error: pulse parity_err, drop the byte. Go to IDLE if stop = 1, or to BREAK if stop = 0; in the latter case frame_err also pulses.
  - BREAK -> IDLE once the synchronised rx has been high for one full bit time.
- Latency: the pushed byte appears on m_data with m_valid=1 on the clk edge after the stop-bit decision.
- FIFO rules:
  - Pop occurs when m_valid && m_ready.
  - Push to a full FIFO: the byte is dropped, overrun pulses, contents are unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun, level unchanged.
  - Push and pop in the same cycle while empty is impossible (the byte is not yet visible), so the push simply fills the FIFO.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the PARITY state and the parity check are built, using PARITY_ODD to select the parity sense; parity_err is live.
- Undefined: the frame is start + DATA_BITS + stop, and parity_err is constant 0.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - UART_OVERSAMPLE_DEF = 16.
  - Helper function div_calc(CLK_HZ, BAUD, OVERSAMPLE).
- Sub-module rx_byte_fifo:
  - Parameters WIDTH and DEPTH.
  - FWFT register-array FIFO with push, full, pop, valid, data and level.
  - Reusable later for the TX path.

Test Plan:
Bench parameters: CLK_HZ=1_600_000, BAUD=100_000, OVERSAMPLE=16 (DIV=1, 16 clk per bit), DEPTH=4, m_ready=1 unless stated.
1. Send 0x55 -> m_valid=1 one clk after the stop decision, m_data=0x55, level 1 -> 0 on the pop, no error pulses.
2. Glitch: rx low for 5 clk, then high -> no byte, no pulses, FSM back in IDLE. A following 0x50 is received intact.
3. Send 0x41 with stop bit 0, then hold rx high for 16 clk -> one frame_err pulse, level stays 0. A following 0x0A is received correctly.
4. m_ready=0, send "UP,12" -> level=4, overrun pulses once on '2'. Then m_ready=1 -> pops 0x55, 0x50, 0x2C, 0x31 in order.
5. FIFO full with m_ready=1 on the same cycle the 5th byte is pushed -> no overrun, level stays 4.
6. Reset for 3 clk mid-data of 0x31 -> m_valid=0, level=0. The next byte 0x34 is received correctly.
   - With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x41 with parity bit 1 -> parity_err pulses, no push.
